// File: rtl/datapath_core_if.sv
// Control-strobe and memory-port bundle between the microcode sequencer and datapath_core.
// The sequencer/bench side uses the master modport; the datapath uses the slave modport.
interface datapath_core_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_REGS);

    logic              i_button;
    logic              i_stepMode;
    logic              i_ctrlHlt;
    logic [2:0]        i_busSrc;
    logic [DATA_W-1:0] i_imm;
    logic              i_regWr;
    logic [SEL_W-1:0]  i_regWrSel;
    logic [SEL_W-1:0]  i_regBusSel;
    logic [SEL_W-1:0]  i_regAluSel;
    logic [2:0]        i_aluOp;
    logic              i_aluWr;
    logic              i_pcLoad;
    logic              i_pcIncr;
    logic              i_memAddrEn;
    logic              i_memWe;
    logic [DATA_W-1:0] i_memRdata;
    logic [DATA_W-1:0] o_bus;
    logic [DATA_W-1:0] o_memAddr;
    logic [DATA_W-1:0] o_memWdata;
    logic              o_memWe;
    logic [DATA_W-1:0] o_pc;
    logic              o_flagN;
    logic              o_flagZ;
    logic              o_flagC;
    logic              o_halted;
    logic              o_busError;

    modport slave (
        input  i_button, i_stepMode, i_ctrlHlt, i_busSrc, i_imm, i_regWr, i_regWrSel,
               i_regBusSel, i_regAluSel, i_aluOp, i_aluWr, i_pcLoad, i_pcIncr,
               i_memAddrEn, i_memWe, i_memRdata,
        output o_bus, o_memAddr, o_memWdata, o_memWe, o_pc, o_flagN, o_flagZ, o_flagC,
               o_halted, o_busError
    );

    modport master (
        output i_button, i_stepMode, i_ctrlHlt, i_busSrc, i_imm, i_regWr, i_regWrSel,
               i_regBusSel, i_regAluSel, i_aluOp, i_aluWr, i_pcLoad, i_pcIncr,
               i_memAddrEn, i_memWe, i_memRdata,
        input  o_bus, o_memAddr, o_memWdata, o_memWe, o_pc, o_flagN, o_flagZ, o_flagC,
               o_halted, o_busError
    );
endinterface

// File: rtl/datapath_core.sv
// Single-bus datapath: register file, ALU accumulator with N/Z/C, PC and memory port,
// frozen by a run/halt/step FSM through an internal clock enable (no gated clock).
module datapath_core #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    datapath_core_if.slave  io
);
    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              btn_prev_q;
    logic              press;
    logic              en;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] mem_addr_q;
    logic              flag_n_q, flag_z_q, flag_c_q;
    logic              bus_err_q;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_a, alu_res;
    logic [DATA_W:0]   alu_sum;
    logic              alu_c;

    assign press = io.i_button & ~btn_prev_q;

    // Run/halt/step next state; the enable is high in every state but HALT.
    always_comb begin
        state_d = state_q;
        en      = (state_q != ST_HALT);
        case (state_q)
            ST_RUN:  if (io.i_ctrlHlt || io.i_stepMode) state_d = ST_HALT;
            ST_HALT: if (press) state_d = io.i_stepMode ? ST_STEP : ST_RUN;
            ST_STEP: state_d = (io.i_stepMode || io.i_ctrlHlt) ? ST_HALT : ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Shared bus source mux; illegal sources read as zero.
    always_comb begin
        case (io.i_busSrc)
            3'd1:    bus = acc_q;
            3'd2:    bus = regs_q[io.i_regBusSel];
            3'd3:    bus = io.i_memRdata;
            3'd4:    bus = pc_q;
            3'd5:    bus = io.i_imm;
            default: bus = '0;
        endcase
    end

    // ALU: A from the register file, B from the bus; SUB computes A + ~B + 1.
    always_comb begin
        alu_a   = regs_q[io.i_regAluSel];
        alu_sum = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (io.i_aluOp)
            3'd0: begin
                alu_sum = {1'b0, alu_a} + {1'b0, bus};
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
            end
            3'd1: begin
                alu_sum = {1'b0, alu_a} + {1'b0, ~bus} + (DATA_W+1)'(1);
                alu_res = alu_sum[DATA_W-1:0];
                alu_c   = alu_sum[DATA_W];
            end
            3'd2: alu_res = alu_a & bus;
            3'd3: alu_res = alu_a | bus;
            3'd4: alu_res = alu_a ^ bus;
            3'd5: begin
                alu_res = {alu_a[DATA_W-2:0], 1'b0};
                alu_c   = alu_a[DATA_W-1];
            end
            3'd6: begin
                alu_res = {1'b0, alu_a[DATA_W-1:1]};
                alu_c   = alu_a[0];
            end
            default: alu_res = bus;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (io.i_pcLoad)      pc_d = bus;
        else if (io.i_pcIncr) pc_d = pc_q + DATA_W'(1);
    end

    // FSM and button history run every cycle; all other state waits on the enable.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_RUN;
            btn_prev_q <= 1'b0;
            acc_q      <= '0;
            pc_q       <= '0;
            mem_addr_q <= '0;
            flag_n_q   <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= io.i_button;
            if (en) begin
                pc_q <= pc_d;
                if (io.i_regWr)     regs_q[io.i_regWrSel] <= bus;
                if (io.i_memAddrEn) mem_addr_q <= bus;
                if (io.i_busSrc > 3'd5) bus_err_q <= 1'b1;
                if (io.i_aluWr) begin
                    acc_q    <= alu_res;
                    flag_n_q <= alu_res[DATA_W-1];
                    flag_z_q <= (alu_res == '0);
                    flag_c_q <= alu_c;
                end
            end
        end
    end

    assign io.o_bus      = bus;
    assign io.o_memWdata = bus;
    assign io.o_memAddr  = mem_addr_q;
    assign io.o_memWe    = io.i_memWe & en;
    assign io.o_pc       = pc_q;
    assign io.o_flagN    = flag_n_q;
    assign io.o_flagZ    = flag_z_q;
    assign io.o_flagC    = flag_c_q;
    assign io.o_halted   = (state_q == ST_HALT);
    assign io.o_busError = bus_err_q;
endmodule

// File: tb/tb_datapath_core.sv
// Self-checking bench for datapath_core: per-cycle comparison against an arithmetic
// reference model, an ALU vector table, directed halt/step/error sequences and random traffic.
module tb_datapath_core;
    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int MASK = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    datapath_core_if #(.DATA_W(DW), .NUM_REGS(NR)) dif ();
    datapath_core #(.DATA_W(DW), .NUM_REGS(NR)) dut (.i_clk(clk), .i_reset(rst), .io(dif));

    int checks = 0;
    int failures = 0;

    // Reference model state: plain integers, a halted flag and a pending-step flag.
    int m_regs [NR];
    int m_acc, m_pc, m_addr;
    bit m_n, m_z, m_c, m_err, m_halt, m_step, m_btn;

    typedef struct {
        int a; int b; int op;
        int res; bit n; bit z; bit c;
    } alu_vec_t;
    alu_vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_bus();
        case (dif.i_busSrc)
            3'd1:    return m_acc;
            3'd2:    return m_regs[dif.i_regBusSel];
            3'd3:    return int'(dif.i_memRdata);
            3'd4:    return m_pc;
            3'd5:    return int'(dif.i_imm);
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 0;
        m_acc = 0; m_pc = 0; m_addr = 0;
        m_n = 0; m_z = 0; m_c = 0; m_err = 0;
        m_halt = 0; m_step = 0; m_btn = 0;
    endtask

    task automatic model_edge();
        int b, a, s, r;
        bit c, press;
        if (rst) begin
            model_reset();
            return;
        end
        press = dif.i_button && !m_btn;
        m_btn = dif.i_button;
        if (!m_halt) begin
            b = model_bus();
            a = m_regs[dif.i_regAluSel];
            c = 0;
            case (int'(dif.i_aluOp))
                0: begin s = a + b; r = s & MASK; c = (s >> DW) & 1; end
                1: begin s = a + ((~b) & MASK) + 1; r = s & MASK; c = (s >> DW) & 1; end
                2: r = a & b;
                3: r = a | b;
                4: r = a ^ b;
                5: begin r = (a * 2) & MASK; c = (a >> (DW - 1)) & 1; end
                6: begin r = a / 2; c = a % 2; end
                default: r = b;
            endcase
            if (dif.i_aluWr) begin
                m_acc = r; m_n = (r >> (DW - 1)) & 1; m_z = (r == 0); m_c = c;
            end
            if (dif.i_regWr) m_regs[dif.i_regWrSel] = b;
            if (dif.i_memAddrEn) m_addr = b;
            if (int'(dif.i_busSrc) > 5) m_err = 1;
            if (dif.i_pcLoad) m_pc = b;
            else if (dif.i_pcIncr) m_pc = (m_pc + 1) & MASK;
        end
        if (m_step) begin
            m_step = 0;
            m_halt = dif.i_stepMode || dif.i_ctrlHlt;
        end else if (!m_halt) begin
            m_halt = dif.i_ctrlHlt || dif.i_stepMode;
        end else if (press) begin
            m_halt = 0;
            m_step = dif.i_stepMode;
        end
    endtask

    task automatic check_outputs();
        chk("bus", dif.o_bus, model_bus());
        chk("memWdata", dif.o_memWdata, model_bus());
        chk("memWe", dif.o_memWe, int'(dif.i_memWe && !m_halt));
        chk("memAddr", dif.o_memAddr, m_addr);
        chk("pc", dif.o_pc, m_pc);
        chk("flagN", dif.o_flagN, m_n);
        chk("flagZ", dif.o_flagZ, m_z);
        chk("flagC", dif.o_flagC, m_c);
        chk("halted", dif.o_halted, m_halt);
        chk("busError", dif.o_busError, m_err);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        dif.i_busSrc = 3'd0; dif.i_imm = '0; dif.i_regWr = 0; dif.i_regWrSel = '0;
        dif.i_regBusSel = '0; dif.i_regAluSel = '0; dif.i_aluOp = 3'd0; dif.i_aluWr = 0;
        dif.i_pcLoad = 0; dif.i_pcIncr = 0; dif.i_memAddrEn = 0; dif.i_memWe = 0;
        dif.i_memRdata = '0; dif.i_ctrlHlt = 0;
    endtask

    initial begin
        vecs[0]  = '{a: 'h05, b: 'h07, op: 0, res: 'h0C, n: 0, z: 0, c: 0};
        vecs[1]  = '{a: 'h05, b: 'h07, op: 1, res: 'hFE, n: 1, z: 0, c: 0};
        vecs[2]  = '{a: 'hFF, b: 'h01, op: 0, res: 'h00, n: 0, z: 1, c: 1};
        vecs[3]  = '{a: 'h07, b: 'h05, op: 1, res: 'h02, n: 0, z: 0, c: 1};
        vecs[4]  = '{a: 'h05, b: 'h05, op: 1, res: 'h00, n: 0, z: 1, c: 1};
        vecs[5]  = '{a: 'hF0, b: 'h3C, op: 2, res: 'h30, n: 0, z: 0, c: 0};
        vecs[6]  = '{a: 'hF0, b: 'h0F, op: 3, res: 'hFF, n: 1, z: 0, c: 0};
        vecs[7]  = '{a: 'hAA, b: 'hAA, op: 4, res: 'h00, n: 0, z: 1, c: 0};
        vecs[8]  = '{a: 'h81, b: 'h00, op: 5, res: 'h02, n: 0, z: 0, c: 1};
        vecs[9]  = '{a: 'h81, b: 'h00, op: 6, res: 'h40, n: 0, z: 0, c: 1};
        vecs[10] = '{a: 'h00, b: 'h80, op: 7, res: 'h80, n: 1, z: 0, c: 0};

        idle();
        dif.i_button = 0; dif.i_stepMode = 0;
        rst = 1;
        @(posedge clk); model_edge(); #1;
        tick();
        rst = 0;
        chk("reset pc", dif.o_pc, 0);
        chk("reset halted", dif.o_halted, 0);
        chk("reset busError", dif.o_busError, 0);

        // Immediate onto the bus, then read back through the register file.
        dif.i_busSrc = 3'd5; dif.i_imm = 8'h2A; dif.i_regWr = 1; dif.i_regWrSel = 2'd1;
        #1 chk("imm bus", dif.o_bus, 'h2A);
        tick();
        idle(); dif.i_busSrc = 3'd2; dif.i_regBusSel = 2'd1;
        #1 chk("reg1 bus", dif.o_bus, 'h2A);
        tick();

        foreach (vecs[k]) begin
            idle(); dif.i_busSrc = 3'd5; dif.i_imm = DW'(vecs[k].a); dif.i_regWr = 1;
            tick();
            idle(); dif.i_busSrc = 3'd5; dif.i_imm = DW'(vecs[k].b);
            dif.i_aluOp = 3'(vecs[k].op); dif.i_aluWr = 1;
            tick();
            idle(); dif.i_busSrc = 3'd1;
            #1;
            chk($sformatf("alu%0d acc", k), dif.o_bus, vecs[k].res);
            chk($sformatf("alu%0d N", k), dif.o_flagN, vecs[k].n);
            chk($sformatf("alu%0d Z", k), dif.o_flagZ, vecs[k].z);
            chk($sformatf("alu%0d C", k), dif.o_flagC, vecs[k].c);
            tick();
        end

        // PC wrap, then load beating increment.
        idle(); dif.i_busSrc = 3'd5; dif.i_imm = 8'hFF; dif.i_pcLoad = 1;
        tick();
        idle(); dif.i_pcIncr = 1;
        tick();
        chk("pc wrap", dif.o_pc, 0);
        idle(); dif.i_busSrc = 3'd5; dif.i_imm = 8'h40; dif.i_pcLoad = 1; dif.i_pcIncr = 1;
        tick();
        chk("pc load prio", dif.o_pc, 'h40);

        // Halt with a write in the halting cycle, frozen strobes, button resume.
        idle(); dif.i_busSrc = 3'd5; dif.i_imm = 8'h11; dif.i_regWr = 1; dif.i_regWrSel = 2'd2;
        dif.i_ctrlHlt = 1;
        tick();
        chk("halt entered", dif.o_halted, 1);
        idle(); dif.i_busSrc = 3'd5; dif.i_imm = 8'h99; dif.i_regWr = 1; dif.i_regWrSel = 2'd2;
        dif.i_memWe = 1; dif.i_memAddrEn = 1; dif.i_pcIncr = 1;
        #1 chk("memWe halted", dif.o_memWe, 0);
        tick(); tick();
        chk("pc frozen", dif.o_pc, 'h40);
        idle(); dif.i_busSrc = 3'd2; dif.i_regBusSel = 2'd2;
        #1 chk("reg2 kept", dif.o_bus, 'h11);
        dif.i_button = 1;
        tick();
        chk("resumed", dif.o_halted, 0);
        dif.i_ctrlHlt = 1;
        tick();
        dif.i_ctrlHlt = 0;
        tick(); tick();
        chk("held button no retrigger", dif.o_halted, 1);
        dif.i_button = 0;
        tick();
        dif.i_button = 1;
        tick();
        chk("second resume", dif.o_halted, 0);
        dif.i_button = 0;

        // Single-step: one PC increment per press.
        idle(); dif.i_busSrc = 3'd5; dif.i_imm = 8'h10; dif.i_pcLoad = 1;
        tick();
        idle(); dif.i_stepMode = 1; dif.i_pcIncr = 1;
        tick();
        chk("step entry pc", dif.o_pc, 'h11);
        chk("step entry halted", dif.o_halted, 1);
        tick();
        for (int p = 0; p < 3; p++) begin
            dif.i_button = 1;
            tick();
            chk("step active", dif.o_halted, 0);
            dif.i_button = 0;
            tick();
            chk("step rehalt", dif.o_halted, 1);
            tick();
            chk("step pc", dif.o_pc, 'h12 + p);
        end
        dif.i_stepMode = 0; dif.i_pcIncr = 0; dif.i_button = 1;
        tick();
        dif.i_button = 0;
        tick();
        chk("leave step", dif.o_halted, 0);

        // Illegal source while halted is ignored; while running it latches until reset.
        idle(); dif.i_ctrlHlt = 1;
        tick();
        idle(); dif.i_busSrc = 3'd7;
        tick();
        chk("illegal halted", dif.o_busError, 0);
        dif.i_busSrc = 3'd0; dif.i_button = 1;
        tick();
        dif.i_button = 0; dif.i_busSrc = 3'd6;
        #1 chk("illegal bus zero", dif.o_bus, 0);
        tick();
        chk("busError set", dif.o_busError, 1);
        dif.i_busSrc = 3'd5; dif.i_imm = 8'h33;
        tick(); tick();
        chk("busError sticky", dif.o_busError, 1);
        dif.i_ctrlHlt = 1;
        tick();
        dif.i_ctrlHlt = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("busError cleared", dif.o_busError, 0);
        chk("reset from halt", dif.o_halted, 0);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 39);
            dif.i_busSrc    = (r < 38) ? 3'(r % 6) : 3'(6 + r % 2);
            dif.i_imm       = DW'($urandom);
            dif.i_memRdata  = DW'($urandom);
            dif.i_regWr     = $urandom_range(0, 1) != 0;
            dif.i_regWrSel  = 2'($urandom);
            dif.i_regBusSel = 2'($urandom);
            dif.i_regAluSel = 2'($urandom);
            dif.i_aluOp     = 3'($urandom);
            dif.i_aluWr     = $urandom_range(0, 1) != 0;
            dif.i_pcLoad    = $urandom_range(0, 5) == 0;
            dif.i_pcIncr    = $urandom_range(0, 1) != 0;
            dif.i_memAddrEn = $urandom_range(0, 2) == 0;
            dif.i_memWe     = $urandom_range(0, 1) != 0;
            dif.i_ctrlHlt   = $urandom_range(0, 9) == 0;
            dif.i_stepMode  = $urandom_range(0, 7) == 0;
            dif.i_button    = $urandom_range(0, 2) == 0;
            rst             = $urandom_range(0, 59) == 0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/datapath_core.md
Name: datapath_core

Overview:
- Parametrised successor to the 8-bit single-bus datapath. One shared bus of width DATA_W, NUM_REGS register file, registered ALU accumulator with N/Z/C flags, PC, and an external memory port.
- All control strobes are inputs from the microcode sequencer.
- Halting uses a synchronous run/halt/step FSM that drives an internal clock enable. There is no gated clock.

Parameters:
DATA_W, 8, width of bus, registers, ALU, PC and memory address (>=4)
NUM_REGS, 4, number of general registers (power of 2, >=2); SEL_W = $clog2(NUM_REGS)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_button  in  1  resume/step button (synchronous level)
i_stepMode  in  1  1 = single-step operation
i_ctrlHlt  in  1  halt request from control
i_busSrc  in  3  bus source: 0 none, 1 acc, 2 reg, 3 mem, 4 PC, 5 imm, 6-7 illegal
i_imm  in  DATA_W  immediate from control
i_regWr  in  1  write bus into reg[i_regWrSel]
i_regWrSel  in  SEL_W  write register index
i_regBusSel  in  SEL_W  register driven when i_busSrc=2
i_regAluSel  in  SEL_W  register feeding ALU operand A
i_aluOp  in  3  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 PASSB
i_aluWr  in  1  latch ALU result and flags
i_pcLoad  in  1  load PC from bus
i_pcIncr  in  1  increment PC
i_memAddrEn  in  1  latch bus into memory address register
i_memWe  in  1  memory write request
i_memRdata  in  DATA_W  memory read data
o_bus  out  DATA_W  current bus value
o_memAddr  out  DATA_W  memory address register
o_memWdata  out  DATA_W  equals o_bus
o_memWe  out  1  i_memWe & enable
o_pc  out  DATA_W  program counter
o_flagN, o_flagZ, o_flagC  out  1 each  registered ALU flags
o_halted  out  1  1 when FSM is in HALT
o_busError  out  1  sticky illegal-source flag

Behaviour:
- Reset (synchronous, overrides every other input):
  - All registers, acc, PC, memAddr and flags go to 0.
  - o_busError goes to 0, the button history register goes to 0, and the FSM goes to RUN.
- Enable `en` is 1 in RUN and in STEP, 0 in HALT. Every state update other than the FSM and the button history register is qualified by `en`.
- Bus (combinational mux, no contention possible):
  - Sources: acc, reg[i_regBusSel], i_memRdata, PC, i_imm.
  - Source 0 drives all zeros. Sources 6-7 drive zeros and set o_busError on the next edge (only when en=1). o_busError stays set until reset.
- Register file:
  - Write on the edge when en & i_regWr.
  - Reads are combinational from stored state, so a same-cycle write is not visible until the next cycle.
- ALU:
  - Operands: A = reg[i_regAluSel], B = o_bus. Result is DATA_W wide.
  - On en & i_aluWr: acc <= result; N <= result MSB; Z <= (result==0).
  - C flag per op:
    - ADD: carry out.
    - SUB: A + ~B + 1, so C = carry out (1 = no borrow).
    - SHL: shifted-out MSB. SHR: shifted-out LSB, zero fill.
    - AND/OR/XOR/PASSB: C = 0.
  - Flags change only on i_aluWr.
- PC:
  - On en: i_pcLoad takes priority and loads the bus; else i_pcIncr gives PC+1, wrapping to 0 from all-ones.
- Memory port:
  - memAddr <= bus on en & i_memAddrEn.
  - o_memWe is combinational and is 0 whenever en=0.
- Button: btnPrev <= i_button every cycle. A press is i_button & ~btnPrev, and only a 0->1 edge counts.
- FSM transitions:
  - RUN:
    - If i_ctrlHlt, or i_stepMode, go to HALT.
    - Otherwise stay in RUN.
    - The current cycle still executes, including every strobe active in the halting cycle.
  - HALT:
    - On a press with i_stepMode=1, go to STEP.
    - On a press with i_stepMode=0, go to RUN.
    - Otherwise stay in HALT.
    - All state is frozen and o_halted=1.
  - STEP: executes exactly one enabled cycle, then goes to HALT.
    - If i_stepMode was cleared, go to RUN instead, unless i_ctrlHlt is asserted.
- A press while in RUN or STEP is ignored.
- A reset asserted mid-step or mid-halt returns to RUN with cleared state.

Test Plan:
1. Reset; busSrc=5, imm=0x2A, regWr=1, regWrSel=1 for one cycle → o_bus=0x2A, then busSrc=2, regBusSel=1 gives o_bus=0x2A.
2. ALU arithmetic, reg0=0x05:
   - ADD with B=imm 0x07 → acc=0x0C, N=0, Z=0, C=0.
   - SUB → acc=0xFE, N=1, C=0.
   - reg0=0xFF, ADD with B=0x01 → acc=0x00, Z=1, C=1.
3. PC: load 0xFF, then incr → o_pc=0x00. pcLoad and pcIncr together with bus=0x40 → o_pc=0x40.
4. Halt and resume:
   - i_ctrlHlt with regWr of 0x11 in the same cycle → reg written, o_halted=1 on the next cycle.
   - Further regWr/memWe ignored and o_memWe=0 while halted.
   - Button rising edge → o_halted=0 after one cycle.
   - Holding the button high does not retrigger.
5. Step mode: stepMode=1, pcIncr held high → PC advances by exactly 1 per button press, and o_halted returns to 1 after each step.
6. busSrc=6 → o_bus=0x00, o_busError=1 next cycle and stays set across further legal cycles; i_reset clears it to 0.
